// File: rtl/chip_access_arb.sv
// rtl/chip_access_arb.sv - W5300/SL811 chip bus sequencer and Z80/internal arbiter
// Every access runs SETUP, STROBE, HOLD, GAP; Z80 requests win arbitration.
module chip_access_arb #(
  parameter int STB_LEN = 3,
  parameter int GAP_LEN = 1
) (
  input  logic       fclk,
  input  logic       rst_n,
  input  logic       z_req,
  input  logic       z_rnw,
  input  logic [1:0] z_cs,
  input  logic [9:0] z_addr,
  input  logic [7:0] z_wdata,
  output logic [7:0] z_rdata,
  output logic       z_ovr,
  input  logic       i_req,
  input  logic       i_rnw,
  input  logic [1:0] i_cs,
  input  logic [9:0] i_addr,
  input  logic [7:0] i_wdata,
  output logic       i_ack,
  output logic [7:0] i_rdata,
  output logic       w5300_cs_n,
  output logic       sl811_cs_n,
  output logic       brd_n,
  output logic       bwr_n,
  output logic [9:0] bus_addr,
  output logic       bd_oe,
  output logic [7:0] bd_wdata,
  input  logic [7:0] bd_in
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_STROBE,
    S_HOLD,
    S_GAP
  } state_t;

  localparam logic [2:0] STB_M1 = 3'(STB_LEN - 1);
  localparam logic [2:0] GAP_M1 = 3'(GAP_LEN - 1);

  state_t     state;
  logic [2:0] cnt;
  logic       rnw_r;
  logic       owner_int;

  logic       z_pend;
  logic       zh_rnw;
  logic [1:0] zh_cs;
  logic [9:0] zh_addr;
  logic [7:0] zh_wdata;

  logic       arb_pt;
  logic       grant_z;
  logic       start;
  logic       g_rnw;
  logic [1:0] g_cs;
  logic [9:0] g_addr;
  logic [7:0] g_wdata;

  // A Z80 request not yet held is served straight from the input pins.
  always_comb begin
    arb_pt  = (state == S_IDLE) || ((state == S_GAP) && (cnt == 3'd0));
    grant_z = z_pend | z_req;
    start   = arb_pt && (grant_z || i_req);
    g_rnw   = i_rnw;
    g_cs    = i_cs;
    g_addr  = i_addr;
    g_wdata = i_wdata;
    if (z_pend) begin
      g_rnw   = zh_rnw;
      g_cs    = zh_cs;
      g_addr  = zh_addr;
      g_wdata = zh_wdata;
    end else if (z_req) begin
      g_rnw   = z_rnw;
      g_cs    = z_cs;
      g_addr  = z_addr;
      g_wdata = z_wdata;
    end
  end

  always_ff @(posedge fclk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      cnt        <= 3'd0;
      rnw_r      <= 1'b1;
      owner_int  <= 1'b0;
      z_pend     <= 1'b0;
      zh_rnw     <= 1'b1;
      zh_cs      <= 2'b00;
      zh_addr    <= 10'd0;
      zh_wdata   <= 8'd0;
      z_ovr      <= 1'b0;
      z_rdata    <= 8'd0;
      i_rdata    <= 8'd0;
      i_ack      <= 1'b0;
      w5300_cs_n <= 1'b1;
      sl811_cs_n <= 1'b1;
      brd_n      <= 1'b1;
      bwr_n      <= 1'b1;
      bd_oe      <= 1'b0;
      bus_addr   <= 10'd0;
      bd_wdata   <= 8'd0;
    end else begin
      i_ack <= 1'b0;

      if (z_req && z_pend)
        z_ovr <= 1'b1;

      if (arb_pt && grant_z) begin
        z_pend <= 1'b0;
      end else if (z_req && !z_pend) begin
        z_pend   <= 1'b1;
        zh_rnw   <= z_rnw;
        zh_cs    <= z_cs;
        zh_addr  <= z_addr;
        zh_wdata <= z_wdata;
      end

      if (start) begin
        state      <= S_SETUP;
        owner_int  <= ~grant_z;
        rnw_r      <= g_rnw;
        w5300_cs_n <= ~g_cs[0];
        sl811_cs_n <= ~g_cs[1];
        bus_addr   <= g_addr;
        bd_wdata   <= g_wdata;
        bd_oe      <= ~g_rnw;
        brd_n      <= 1'b1;
        bwr_n      <= 1'b1;
      end else begin
        case (state)
          S_IDLE: begin
          end
          S_SETUP: begin
            state <= S_STROBE;
            cnt   <= STB_M1;
            brd_n <= ~rnw_r;
            bwr_n <= rnw_r;
          end
          S_STROBE: begin
            if (cnt == 3'd0) begin
              state <= S_HOLD;
              brd_n <= 1'b1;
              bwr_n <= 1'b1;
              i_ack <= owner_int;
              if (rnw_r) begin
                if (owner_int)
                  i_rdata <= bd_in;
                else
                  z_rdata <= bd_in;
              end
            end else begin
              cnt <= cnt - 3'd1;
            end
          end
          S_HOLD: begin
            state      <= S_GAP;
            cnt        <= GAP_M1;
            w5300_cs_n <= 1'b1;
            sl811_cs_n <= 1'b1;
            bd_oe      <= 1'b0;
          end
          S_GAP: begin
            if (cnt != 3'd0)
              cnt <= cnt - 3'd1;
            else
              state <= S_IDLE;
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_chip_access_arb.sv
// tb/tb_chip_access_arb.sv - directed bench for chip_access_arb with default timing
module tb_chip_access_arb;

  logic       fclk = 1'b0;
  logic       rst_n;
  logic       z_req, z_rnw;
  logic [1:0] z_cs;
  logic [9:0] z_addr;
  logic [7:0] z_wdata;
  logic [7:0] z_rdata;
  logic       z_ovr;
  logic       i_req, i_rnw;
  logic [1:0] i_cs;
  logic [9:0] i_addr;
  logic [7:0] i_wdata;
  logic       i_ack;
  logic [7:0] i_rdata;
  logic       w5300_cs_n, sl811_cs_n, brd_n, bwr_n, bd_oe;
  logic [9:0] bus_addr;
  logic [7:0] bd_wdata;
  logic [7:0] bd_in;

  int total = 0;
  int bad   = 0;

  always #5 fclk = ~fclk;

  chip_access_arb #(.STB_LEN(3), .GAP_LEN(1)) dut (
    .fclk(fclk), .rst_n(rst_n),
    .z_req(z_req), .z_rnw(z_rnw), .z_cs(z_cs), .z_addr(z_addr), .z_wdata(z_wdata),
    .z_rdata(z_rdata), .z_ovr(z_ovr),
    .i_req(i_req), .i_rnw(i_rnw), .i_cs(i_cs), .i_addr(i_addr), .i_wdata(i_wdata),
    .i_ack(i_ack), .i_rdata(i_rdata),
    .w5300_cs_n(w5300_cs_n), .sl811_cs_n(sl811_cs_n), .brd_n(brd_n), .bwr_n(bwr_n),
    .bus_addr(bus_addr), .bd_oe(bd_oe), .bd_wdata(bd_wdata), .bd_in(bd_in)
  );

  task automatic tick();
    @(posedge fclk);
    #1;
  endtask

  task automatic clr_inputs();
    z_req = 0; z_rnw = 1; z_cs = 2'b00; z_addr = 0; z_wdata = 0;
    i_req = 0; i_rnw = 1; i_cs = 2'b00; i_addr = 0; i_wdata = 0;
    bd_in = 0;
  endtask

  task automatic test_reset();
    rst_n = 0;
    clr_inputs();
    repeat (2) tick();
    total++;
    if ({w5300_cs_n, sl811_cs_n, brd_n, bwr_n, bd_oe, i_ack, z_ovr} !== 7'b1111000) begin
      bad++;
      $display("FAIL reset_ctl got=%b exp=%b",
               {w5300_cs_n, sl811_cs_n, brd_n, bwr_n, bd_oe, i_ack, z_ovr}, 7'b1111000);
    end
    total++;
    if ({bus_addr, bd_wdata, z_rdata, i_rdata} !== 34'd0) begin
      bad++;
      $display("FAIL reset_data got=%h exp=0", {bus_addr, bd_wdata, z_rdata, i_rdata});
    end
    rst_n = 1;
    repeat (2) tick();
  endtask

  task automatic test_z80_read();
    logic [4:0] exp;
    z_req = 1; z_rnw = 1; z_cs = 2'b01; z_addr = 10'h155; bd_in = 8'hA5;
    for (int k = 1; k <= 8; k++) begin
      tick();
      if (k == 1) z_req = 0;
      exp = {!(k >= 1 && k <= 5), 1'b1, !(k >= 2 && k <= 4), 1'b1, 1'b0};
      total++;
      if ({w5300_cs_n, sl811_cs_n, brd_n, bwr_n, bd_oe} !== exp) begin
        bad++;
        $display("FAIL rd_bus k=%0d got=%b exp=%b", k,
                 {w5300_cs_n, sl811_cs_n, brd_n, bwr_n, bd_oe}, exp);
      end
      if (k == 1) begin
        total++;
        if (bus_addr !== 10'h155) begin
          bad++;
          $display("FAIL rd_addr got=%h exp=155", bus_addr);
        end
      end
      if (k == 5) begin
        total++;
        if (z_rdata !== 8'hA5) begin
          bad++;
          $display("FAIL rd_data got=%h exp=a5", z_rdata);
        end
        bd_in = 8'h00;
      end
    end
  endtask

  task automatic test_z80_write();
    logic [4:0] exp;
    z_req = 1; z_rnw = 0; z_cs = 2'b10; z_addr = 10'h001; z_wdata = 8'h3C; bd_in = 8'hEE;
    for (int k = 1; k <= 8; k++) begin
      tick();
      if (k == 1) z_req = 0;
      exp = {1'b1, !(k >= 1 && k <= 5), 1'b1, !(k >= 2 && k <= 4), (k >= 1 && k <= 5)};
      total++;
      if ({w5300_cs_n, sl811_cs_n, brd_n, bwr_n, bd_oe} !== exp) begin
        bad++;
        $display("FAIL wr_bus k=%0d got=%b exp=%b", k,
                 {w5300_cs_n, sl811_cs_n, brd_n, bwr_n, bd_oe}, exp);
      end
      if (k >= 1 && k <= 5) begin
        total++;
        if ({bus_addr[0], bd_wdata} !== {1'b1, 8'h3C}) begin
          bad++;
          $display("FAIL wr_data k=%0d got a0=%b d=%h exp a0=1 d=3c", k, bus_addr[0], bd_wdata);
        end
      end
    end
    total++;
    if ({z_rdata, z_ovr} !== {8'hA5, 1'b0}) begin
      bad++;
      $display("FAIL wr_rdata_kept got=%h ovr=%b exp=a5 ovr=0", z_rdata, z_ovr);
    end
  endtask

  task automatic test_simultaneous();
    logic [2:0] exp;
    z_req = 1; z_rnw = 1; z_cs = 2'b01; z_addr = 10'h010;
    i_req = 1; i_rnw = 1; i_cs = 2'b10; i_addr = 10'h2AA;
    bd_in = 8'h5A;
    for (int k = 1; k <= 14; k++) begin
      tick();
      if (k == 1) z_req = 0;
      if (k == 6) bd_in = 8'hC3;
      if (k == 12) i_req = 0;
      exp = {!(k >= 1 && k <= 5), !(k >= 7 && k <= 11), (k == 11)};
      total++;
      if ({w5300_cs_n, sl811_cs_n, i_ack} !== exp) begin
        bad++;
        $display("FAIL sim_seq k=%0d got=%b exp=%b", k, {w5300_cs_n, sl811_cs_n, i_ack}, exp);
      end
      if (k == 7) begin
        total++;
        if (bus_addr !== 10'h2AA) begin
          bad++;
          $display("FAIL sim_iaddr got=%h exp=2aa", bus_addr);
        end
      end
      if (k == 11) begin
        total++;
        if ({z_rdata, i_rdata} !== {8'h5A, 8'hC3}) begin
          bad++;
          $display("FAIL sim_rdata got z=%h i=%h exp z=5a i=c3", z_rdata, i_rdata);
        end
      end
    end
  endtask

  task automatic test_z_during_int();
    logic [4:0] exp;
    i_req = 1; i_rnw = 0; i_cs = 2'b01; i_addr = 10'h0F0; i_wdata = 8'h77;
    bd_in = 8'h81;
    for (int k = 1; k <= 13; k++) begin
      tick();
      if (k == 1) begin
        z_req = 1; z_rnw = 1; z_cs = 2'b10; z_addr = 10'h123;
      end
      if (k == 2) z_req = 0;
      if (k == 6) i_req = 0;
      exp = {!(k >= 1 && k <= 5), !(k >= 7 && k <= 11), !(k >= 2 && k <= 4),
             (k >= 1 && k <= 5), (k == 5)};
      total++;
      if ({w5300_cs_n, sl811_cs_n, bwr_n, bd_oe, i_ack} !== exp) begin
        bad++;
        $display("FAIL zint_seq k=%0d got=%b exp=%b", k,
                 {w5300_cs_n, sl811_cs_n, bwr_n, bd_oe, i_ack}, exp);
      end
      if (k == 7) begin
        total++;
        if (bus_addr !== 10'h123) begin
          bad++;
          $display("FAIL zint_addr got=%h exp=123", bus_addr);
        end
      end
    end
    total++;
    if ({z_rdata, z_ovr} !== {8'h81, 1'b0}) begin
      bad++;
      $display("FAIL zint_end got rdata=%h ovr=%b exp rdata=81 ovr=0", z_rdata, z_ovr);
    end
  endtask

  task automatic test_overrun();
    logic [2:0] exp;
    i_req = 1; i_rnw = 1; i_cs = 2'b01; i_addr = 10'h055;
    bd_in = 8'h99;
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (k == 1) begin
        z_req = 1; z_rnw = 0; z_cs = 2'b10; z_addr = 10'h200; z_wdata = 8'h11;
      end
      if (k == 2) z_req = 0;
      if (k == 3) begin
        z_req = 1; z_addr = 10'h300; z_wdata = 8'h22;
      end
      if (k == 4) z_req = 0;
      if (k == 6) i_req = 0;
      exp = {!(k >= 1 && k <= 5), !(k >= 7 && k <= 11), (k == 5)};
      total++;
      if ({w5300_cs_n, sl811_cs_n, i_ack} !== exp) begin
        bad++;
        $display("FAIL ovr_seq k=%0d got=%b exp=%b", k, {w5300_cs_n, sl811_cs_n, i_ack}, exp);
      end
      if (k == 2 || k == 4) begin
        total++;
        if (z_ovr !== (k == 4)) begin
          bad++;
          $display("FAIL ovr_flag k=%0d got=%b exp=%b", k, z_ovr, (k == 4));
        end
      end
      if (k == 5) begin
        total++;
        if (i_rdata !== 8'h99) begin
          bad++;
          $display("FAIL ovr_irdata got=%h exp=99", i_rdata);
        end
      end
      if (k == 7) begin
        total++;
        if ({bus_addr, bd_wdata} !== {10'h200, 8'h11}) begin
          bad++;
          $display("FAIL ovr_first got addr=%h d=%h exp addr=200 d=11", bus_addr, bd_wdata);
        end
      end
    end
    total++;
    if (z_ovr !== 1'b1) begin
      bad++;
      $display("FAIL ovr_sticky got=%b exp=1", z_ovr);
    end
  endtask

  task automatic test_reset_mid();
    z_req = 1; z_rnw = 1; z_cs = 2'b01; z_addr = 10'h0AA; bd_in = 8'h42;
    tick();
    z_req = 0;
    tick();
    z_req = 1; z_cs = 2'b10; z_addr = 10'h3FF;
    tick();
    z_req = 0;
    total++;
    if ({w5300_cs_n, brd_n} !== 2'b00) begin
      bad++;
      $display("FAIL rst_pre got cs_n=%b brd_n=%b exp 0 0", w5300_cs_n, brd_n);
    end
    #2 rst_n = 0;
    #1;
    total++;
    if ({w5300_cs_n, sl811_cs_n, brd_n, bwr_n, bd_oe, z_ovr} !== 6'b111100) begin
      bad++;
      $display("FAIL rst_async got=%b exp=111100",
               {w5300_cs_n, sl811_cs_n, brd_n, bwr_n, bd_oe, z_ovr});
    end
    #2 rst_n = 1;
    for (int k = 1; k <= 10; k++) begin
      tick();
      total++;
      if ({w5300_cs_n, sl811_cs_n, brd_n, bwr_n, bd_oe} !== 5'b11110) begin
        bad++;
        $display("FAIL rst_stale k=%0d got=%b exp=11110", k,
                 {w5300_cs_n, sl811_cs_n, brd_n, bwr_n, bd_oe});
      end
    end
  endtask

  initial begin
    test_reset();
    test_z80_read();
    test_z80_write();
    test_simultaneous();
    clr_inputs();
    repeat (2) tick();
    test_z_during_int();
    clr_inputs();
    repeat (2) tick();
    test_overrun();
    clr_inputs();
    repeat (2) tick();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
